mem_wb_skid_reg: RTL and testbench

//  Parametrised MEM->WB pipeline register with valid/ready handshake, optional 2-entry skid buffer,

---
 rtl/mem_wb_skid_reg.sv | 105 ++++++++++
 tb/tb_mem_wb_skid_reg.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake, freeze, flush and an
// optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module mem_wb_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 4,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_r_en,
    input  logic              in_wb_en,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mem_r_en,
    output logic              out_wb_en,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [1:0]        count
);

    localparam int unsigned BW = 2 + DEST_W + 2 * DATA_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    state;
    logic [BW-1:0] in_beat;
    logic [BW-1:0] h_beat;
    logic [BW-1:0] s_beat;
    logic          h_valid;
    logic          s_valid;
    logic          acc;
    logic          pop;

    assign in_beat = {in_mem_r_en, in_wb_en, in_dest, in_alu_res, in_mem_data};
    assign h_valid = (state != ST_EMPTY);
    assign s_valid = (state == ST_FULL);

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = ~s_valid & ~freeze;
        end else begin : g_single
            assign in_ready = (~h_valid | out_ready) & ~freeze;
        end
    endgenerate

    assign acc = in_valid & in_ready & ~flush;
    assign pop = h_valid & out_ready & ~freeze & ~flush;

    // State doubles as the occupancy count; FULL is unreachable when SKID=0
    // because in_ready then blocks an accept without a simultaneous pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_EMPTY;
            h_beat <= '0;
            s_beat <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else if (!freeze) begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        h_beat <= in_beat;
                        state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        h_beat <= in_beat;
                    end else if (acc) begin
                        s_beat <= in_beat;
                        state  <= ST_FULL;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        h_beat <= s_beat;
                        state  <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign out_valid    = h_valid;
    assign out_mem_r_en = h_beat[BW-1] & h_valid;
    assign out_wb_en    = h_beat[BW-2] & h_valid;
    assign out_dest     = h_beat[2*DATA_W +: DEST_W];
    assign out_alu_res  = h_beat[DATA_W +: DATA_W];
    assign out_mem_data = h_beat[DATA_W-1:0];
    assign count        = state;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: one SKID=1 instance and one SKID=0
// instance, each with its own expected-beat queue and output monitor.
module tb_mem_wb_skid_reg;

    typedef struct packed {
        logic        mr;
        logic        wb;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] mem;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // SKID=1 instance signals
    logic        flush = 0, freeze = 0, in_valid = 0, out_ready = 0;
    logic        in_mem_r_en = 0, in_wb_en = 0;
    logic [3:0]  in_dest = '0;
    logic [31:0] in_alu_res = '0, in_mem_data = '0;
    logic        in_ready, out_valid, out_mem_r_en, out_wb_en;
    logic [3:0]  out_dest;
    logic [31:0] out_alu_res, out_mem_data;
    logic [1:0]  count;

    // SKID=0 instance signals
    logic        z_in_valid = 0, z_out_ready = 0;
    logic        z_in_mem_r_en = 0, z_in_wb_en = 0;
    logic [3:0]  z_in_dest = '0;
    logic [31:0] z_in_alu_res = '0, z_in_mem_data = '0;
    logic        z_in_ready, z_out_valid, z_out_mem_r_en, z_out_wb_en;
    logic [3:0]  z_out_dest;
    logic [31:0] z_out_alu_res, z_out_mem_data;
    logic [1:0]  z_count;

    mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_r_en(in_mem_r_en), .in_wb_en(in_wb_en), .in_dest(in_dest),
        .in_alu_res(in_alu_res), .in_mem_data(in_mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mem_r_en(out_mem_r_en), .out_wb_en(out_wb_en), .out_dest(out_dest),
        .out_alu_res(out_alu_res), .out_mem_data(out_mem_data), .count(count)
    );

    mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(1'b0), .freeze(1'b0),
        .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_mem_r_en(z_in_mem_r_en), .in_wb_en(z_in_wb_en), .in_dest(z_in_dest),
        .in_alu_res(z_in_alu_res), .in_mem_data(z_in_mem_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_mem_r_en(z_out_mem_r_en), .out_wb_en(z_out_wb_en), .out_dest(z_out_dest),
        .out_alu_res(z_out_alu_res), .out_mem_data(z_out_mem_data), .count(z_count)
    );

    beat_t q[$];
    beat_t q0[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic beat_t mk(input logic [3:0] d);
        beat_t b;
        b.mr   = d[0];
        b.wb   = (d != 4'd7);
        b.dest = d;
        b.alu  = {28'h0, d} << 4;
        b.mem  = 32'hA000_0000 | {28'h0, d};
        return b;
    endfunction

    task automatic put(input logic [3:0] d);
        beat_t b;
        b = mk(d);
        in_valid = 1'b1;
        in_mem_r_en = b.mr; in_wb_en = b.wb; in_dest = b.dest;
        in_alu_res = b.alu; in_mem_data = b.mem;
    endtask

    task automatic z_put(input logic [3:0] d);
        beat_t b;
        b = mk(d);
        z_in_valid = 1'b1;
        z_in_mem_r_en = b.mr; z_in_wb_en = b.wb; z_in_dest = b.dest;
        z_in_alu_res = b.alu; z_in_mem_data = b.mem;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: inputs are stable mid-cycle, so a negedge sample sees the handshake of the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready && !freeze && !flush) begin
                if (q.size() == 0) begin
                    check("skid1_unexpected_beat", {124'h0, out_dest}, 128'hFFFF);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    check("skid1_beat", {58'h0, out_mem_r_en, out_wb_en, out_dest, out_alu_res, out_mem_data}, {58'h0, e});
                end
            end
            if (!out_valid) check("skid1_bubble_gating", {126'h0, out_wb_en, out_mem_r_en}, 128'h0);
        end
    end

    always @(negedge clk) begin
        if (!rst && z_out_valid && z_out_ready) begin
            if (q0.size() == 0) begin
                check("skid0_unexpected_beat", {124'h0, z_out_dest}, 128'hFFFF);
            end else begin
                beat_t e;
                e = q0.pop_front();
                check("skid0_beat", {58'h0, z_out_mem_r_en, z_out_wb_en, z_out_dest, z_out_alu_res, z_out_mem_data}, {58'h0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_dest", out_dest, 0);
        step(); rst = 1'b0;

        // Stream: one beat per cycle, count pinned at 1
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(); put(4'(i)); q.push_back(mk(4'(i)));
            @(negedge clk);
            if (i > 1) begin
                check("stream_count", count, 1);
                check("stream_in_ready", in_ready, 1);
            end
        end
        step(); in_valid = 1'b0;
        @(negedge clk); check("stream_tail_count", count, 1);
        step();
        @(negedge clk); check("stream_empty", count, 0);

        // Backpressure fills the skid entry
        out_ready = 1'b0;
        step(); put(4'd10); q.push_back(mk(4'd10));
        step(); put(4'd11); q.push_back(mk(4'd11));
        @(negedge clk); check("bp_count1", count, 1);
        check("bp_in_ready1", in_ready, 1);
        step(); in_valid = 1'b0;
        @(negedge clk); check("bp_count2", count, 2);
        check("bp_in_ready_full", in_ready, 0);
        step(); out_ready = 1'b1;
        @(negedge clk); check("bp_in_ready_popA", in_ready, 0);
        step();
        @(negedge clk); check("bp_count_after_A", count, 1);
        check("bp_in_ready_after_A", in_ready, 1);
        step();
        @(negedge clk); check("bp_drained", count, 0);

        // Freeze holds head and blocks both handshakes
        out_ready = 1'b0;
        step(); put(4'd5); q.push_back(mk(4'd5));
        step(); in_valid = 1'b0;
        step(); freeze = 1'b1; out_ready = 1'b1; put(4'd6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_in_ready", in_ready, 0);
            check("frz_out_dest", out_dest, 5);
            check("frz_count", count, 1);
            step();
        end
        freeze = 1'b0; q.push_back(mk(4'd6));
        @(negedge clk); check("frz_release_in_ready", in_ready, 1);
        step(); in_valid = 1'b0;
        @(negedge clk); check("frz_new_head", out_dest, 6);
        step();
        @(negedge clk); check("frz_drained", count, 0);

        // Flush with two held entries and a beat on the input
        out_ready = 1'b0;
        step(); put(4'd12); q.push_back(mk(4'd12));
        step(); put(4'd13); q.push_back(mk(4'd13));
        step(); in_valid = 1'b0;
        @(negedge clk); check("fl_count_pre", count, 2);
        step(); flush = 1'b1; put(4'd9);
        step(); flush = 1'b0; in_valid = 1'b0; q.delete();
        @(negedge clk);
        check("fl_count", count, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_out_wb_en", out_wb_en, 0);
        out_ready = 1'b1;
        repeat (3) step();

        // Flush overrides freeze
        out_ready = 1'b0;
        step(); put(4'd14); q.push_back(mk(4'd14));
        step(); in_valid = 1'b0;
        @(negedge clk); check("flfrz_count_pre", count, 1);
        step(); flush = 1'b1; freeze = 1'b1;
        step(); flush = 1'b0; freeze = 1'b0; q.delete();
        @(negedge clk); check("flfrz_count", count, 0);

        // Asynchronous reset with count=2
        step(); put(4'd2); q.push_back(mk(4'd2));
        step(); put(4'd3); q.push_back(mk(4'd3));
        step(); in_valid = 1'b0;
        @(negedge clk); check("ar_count_pre", count, 2);
        step(); rst = 1'b1; q.delete();
        #1; check("ar_async_count", count, 0);
        @(negedge clk);
        check("ar_count", count, 0);
        check("ar_out_valid", out_valid, 0);
        check("ar_out_wb_en", out_wb_en, 0);
        check("ar_in_ready", in_ready, 1);
        step(); rst = 1'b0;

        // SKID=0: combinational in_ready, load and pop on the same edge
        step(); z_put(4'd3); q0.push_back(mk(4'd3));
        step(); z_in_valid = 1'b0;
        @(negedge clk);
        check("s0_count_held", z_count, 1);
        check("s0_in_ready_blocked", z_in_ready, 0);
        step(); z_out_ready = 1'b1; z_put(4'd4); q0.push_back(mk(4'd4));
        @(negedge clk); check("s0_in_ready_comb", z_in_ready, 1);
        step(); z_in_valid = 1'b0;
        @(negedge clk);
        check("s0_count_swap", z_count, 1);
        check("s0_out_dest", z_out_dest, 4);
        step(); z_out_ready = 1'b0;
        @(negedge clk); check("s0_drained", z_count, 0);

        // Drain with a bounded wait
        out_ready = 1'b1; z_out_ready = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || q0.size() != 0); i++) step();
        check("final_queue1_empty", q.size(), 0);
        check("final_queue0_empty", q0.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
